// File: rtl/subtractor_16b_pipe_if.sv
// ----------------------------------------------------------------------------
// subtractor_16b_pipe_if
// Bundle of the operand/result handshake signals of subtractor_16b_pipe.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1. A producer holds its payload stable while valid=1 and ready=0.
// The ready signal never depends combinationally on the matching valid.
//
// Signals:
//   in_valid  : operand set present on a, b, bin
//   in_ready  : pipe can accept an operand set this cycle
//   a, b      : 16-bit minuend / subtrahend
//   bin       : borrow-in
//   out_valid : result present on diff, bout, ovf
//   out_ready : downstream accepts the result this cycle
//   diff      : 16-bit difference
//   bout      : borrow-out
//   ovf       : two's-complement signed overflow
//
// Modports:
//   master : the environment side (drives operands, consumes results)
//   slave  : the subtractor side
// ----------------------------------------------------------------------------
interface subtractor_16b_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf
    );
endinterface

// File: rtl/subtractor_16b_pipe.sv
// ----------------------------------------------------------------------------
// subtractor_16b_pipe
// Two-stage pipelined 16-bit subtractor: diff = (a - b - bin) mod 2^16,
// evaluated as a + ~b + ~bin with a Kogge-Stone parallel-prefix carry network.
//
// Stage S1 holds per-bit generate/propagate, the carry-in and the operand
// sign bits. Stage S2 holds the finished diff, bout and ovf.
//
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset (discards all in-flight results)
//   bus : subtractor_16b_pipe_if.slave handshake/data bundle
// ----------------------------------------------------------------------------
module subtractor_16b_pipe (
    input  logic                  clk,
    input  logic                  rst,
    subtractor_16b_pipe_if.slave  bus
);

    // Stage S1
    logic        r_s1_valid;
    logic [15:0] r_g;
    logic [15:0] r_p;
    logic        r_cin;
    logic        r_a15;
    logic        r_b15;

    // Stage S2
    logic        r_s2_valid;
    logic [15:0] r_diff;
    logic        r_bout;
    logic        r_ovf;

    // Control
    logic        w_in_ready;
    logic        w_in_xfer;
    logic        w_advance;

    // Prefix network
    logic [15:0] w_gg;
    logic [15:0] w_pg;
    logic [15:0] w_gn;
    logic [15:0] w_pn;
    logic [16:0] w_c;
    logic [15:0] w_diff;
    logic        w_bout;
    logic        w_ovf;

    // S1 may move on when S2 is empty or S2 is being drained this edge.
    assign w_advance  = r_s1_valid && (!r_s2_valid || bus.out_ready);
    // Only the fully stalled pipe refuses input; held low during reset.
    assign w_in_ready = !rst && (!r_s1_valid || !r_s2_valid || bus.out_ready);
    assign w_in_xfer  = bus.in_valid && w_in_ready;

    // S1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_g        <= '0;
            r_p        <= '0;
            r_cin      <= 1'b0;
            r_a15      <= 1'b0;
            r_b15      <= 1'b0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_g        <= bus.a & ~bus.b;
                r_p        <= bus.a ^ ~bus.b;
                r_cin      <= ~bus.bin;
                r_a15      <= bus.a[15];
                r_b15      <= bus.b[15];
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Kogge-Stone prefix: four combine levels give group (G,P) over [i:0];
    // the carry-in is folded in afterwards as a final combine.
    always_comb begin
        w_gg = r_g;
        w_pg = r_p;
        w_gn = '0;
        w_pn = '0;
        w_c  = '0;
        for (int lv = 0; lv < 4; lv++) begin
            w_gn = w_gg;
            w_pn = w_pg;
            for (int i = 0; i < 16; i++) begin
                if (i >= (1 << lv)) begin
                    w_gn[i] = w_gg[i] | (w_pg[i] & w_gg[i - (1 << lv)]);
                    w_pn[i] = w_pg[i] & w_pg[i - (1 << lv)];
                end
            end
            w_gg = w_gn;
            w_pg = w_pn;
        end
        w_c[0] = r_cin;
        for (int i = 0; i < 16; i++) begin
            w_c[i+1] = w_gg[i] | (w_pg[i] & r_cin);
        end
    end

    assign w_diff = r_p ^ w_c[15:0];
    // Carry out of a + ~b + ~bin is the inverse of the borrow.
    assign w_bout = ~w_c[16];
    assign w_ovf  = (r_a15 != r_b15) && (w_diff[15] != r_a15);

    // S2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_diff     <= '0;
            r_bout     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_advance) begin
                r_s2_valid <= 1'b1;
                r_diff     <= w_diff;
                r_bout     <= w_bout;
                r_ovf      <= w_ovf;
            end else if (bus.out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_s2_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;

endmodule
